// File: rtl/bitty_pkg.sv
// Shared types and encodings for the Bitty program sequencer.
// Optional watchdog build switch used by the top level: BITTY_FETCH_WDT_EN.
package bitty_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_ISSUE  = 3'd4,
        ST_EXEC   = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Low two instruction bits that mark a locally resolved branch.
    localparam logic [1:0] OPC_BRANCH = 2'b10;

    // Branch condition field, inst[3:2].
    localparam logic [1:0] COND_EQ = 2'd0;
    localparam logic [1:0] COND_GT = 2'd1;
    localparam logic [1:0] COND_LT = 2'd2;
    localparam logic [1:0] COND_AL = 2'd3;

    // Compare result from the core; encoding 3 is reserved and matches nothing.
    localparam logic [1:0] CMP_EQ = 2'd0;
    localparam logic [1:0] CMP_GT = 2'd1;
    localparam logic [1:0] CMP_LT = 2'd2;

    localparam logic [15:0] DEFAULT_HALT_WORD = 16'hFFFF;

    // True when a branch with condition 'cond' is taken for compare result 'cmp'.
    function automatic logic branch_taken(input logic [1:0] cond, input logic [1:0] cmp);
        logic taken;
        unique case (cond)
            COND_EQ: taken = (cmp == CMP_EQ);
            COND_GT: taken = (cmp == CMP_GT);
            COND_LT: taken = (cmp == CMP_LT);
            default: taken = 1'b1; // COND_AL
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/bitty_branch_unit.sv
// Combinational branch resolver: picks the branch target or the fall-through pc.
module bitty_branch_unit
    import bitty_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [1:0]        cond,
    input  logic [1:0]        cmp_in,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] next_pc
);

    // Taken branches load the target; otherwise step to the next word (wraps).
    always_comb begin
        next_pc = branch_taken(cond, cmp_in) ? target : pc + ADDR_W'(1);
    end

endmodule

// File: rtl/bitty_fetch_seq.sv
// Bitty program sequencer: owns the pc, fetches instructions over req/gnt/rvalid,
// resolves branches locally and hands every other instruction to the core.
// Build option: define BITTY_FETCH_WDT_EN to add the EXEC watchdog (wdt_err).
module bitty_fetch_seq
    import bitty_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [15:0]       HALT_WORD  = DEFAULT_HALT_WORD,
    parameter int                WDT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       core_inst,
    output logic              core_start,
    input  logic              core_done,
    input  logic [1:0]        cmp_in,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              wdt_err
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_branch_pc;
    logic [15:0]       r_inst;
    logic [15:0]       r_core_inst;
    logic              w_wdt_trip;

    bitty_branch_unit #(
        .ADDR_W (ADDR_W)
    ) u_branch (
        .cond    (r_inst[3:2]),
        .cmp_in  (cmp_in),
        .pc      (r_pc),
        .target  (r_inst[ADDR_W+3:4]),
        .next_pc (w_branch_pc)
    );

    // Next-state and next-pc selection.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        unique case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_FETCH;
            ST_FETCH:  if (mem_gnt) w_state_nxt = ST_WAIT;
            ST_WAIT:   if (mem_rvalid) w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (r_inst == HALT_WORD) begin
                    w_state_nxt = ST_HALT;
                end else if (r_inst[1:0] == OPC_BRANCH) begin
                    w_pc_nxt    = w_branch_pc;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE:  w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                // A done in the same cycle as the watchdog limit still completes normally.
                if (core_done) begin
                    w_pc_nxt    = r_pc + ADDR_W'(1);
                    w_state_nxt = ST_FETCH;
                end else if (w_wdt_trip) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (start) begin
                    w_pc_nxt    = RESET_PC;
                    w_state_nxt = ST_FETCH;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State and pc registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Capture fetched words; load the core's instruction only when a non-branch issues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inst      <= '0;
            r_core_inst <= '0;
        end else begin
            if (r_state == ST_WAIT && mem_rvalid) r_inst <= mem_rdata;
            if (r_state == ST_DECODE && w_state_nxt == ST_ISSUE) r_core_inst <= r_inst;
        end
    end

`ifdef BITTY_FETCH_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_wdt_err;

    // Trip on the WDT_CYCLES-th EXEC cycle that ends without core_done.
    assign w_wdt_trip = (r_state == ST_EXEC) && !core_done
                        && (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    // EXEC cycle counter (cleared in ISSUE, i.e. on entry) and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdt_cnt <= '0;
            r_wdt_err <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_wdt_cnt <= '0;
            end else if (r_state == ST_EXEC) begin
                r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
            end
            if (w_wdt_trip) r_wdt_err <= 1'b1;
        end
    end

    assign wdt_err = r_wdt_err;
`else
    // No watchdog: EXEC waits for core_done indefinitely.
    assign w_wdt_trip = 1'b0;
    assign wdt_err    = 1'b0;
`endif

    // Outputs decode straight from state so reset drops mem_req/core_start at once.
    assign mem_req    = (r_state == ST_FETCH);
    assign mem_addr   = r_pc;
    assign pc         = r_pc;
    assign core_inst  = r_core_inst;
    assign core_start = (r_state == ST_ISSUE);
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_bitty_fetch_seq.sv
// Directed testbench for bitty_fetch_seq: inputs driven and outputs sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_bitty_fetch_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [15:0] core_inst;
    logic        core_start;
    logic        core_done;
    logic [1:0]  cmp_in;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        wdt_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;

    always #5 clk = ~clk;

    bitty_fetch_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .core_inst  (core_inst),
        .core_start (core_start),
        .core_done  (core_done),
        .cmp_in     (cmp_in),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .wdt_err    (wdt_err)
    );

    // Count core_start samples; each instruction must produce exactly one.
    always @(negedge clk) if (core_start === 1'b1) n_starts++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Entered in FETCH; withholds gnt for gnt_wait cycles, returns in DECODE.
    task automatic do_fetch(input logic [7:0] addr, input int gnt_wait, input logic [15:0] word);
        for (int i = 0; i < gnt_wait; i++) begin
            check("req_held", 32'(mem_req), 32'd1);
            check("addr_held", 32'(mem_addr), 32'(addr));
            tick();
        end
        check("req", 32'(mem_req), 32'd1);
        check("addr", 32'(mem_addr), 32'(addr));
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("req_off_in_wait", 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
    endtask

    // Fetch a branch word, present cmp during DECODE, check the next fetch address.
    task automatic do_branch(input logic [7:0] addr, input int gnt_wait, input logic [15:0] word,
                             input logic [1:0] cmp, input logic [7:0] exp_pc);
        do_fetch(addr, gnt_wait, word);
        check("no_start_decode", 32'(core_start), 32'd0);
        cmp_in = cmp;
        tick();
        cmp_in = 2'd3;
        check("br_start", 32'(core_start), 32'd0);
        check("br_req", 32'(mem_req), 32'd1);
        check("br_addr", 32'(mem_addr), 32'(exp_pc));
    endtask

    // Fetch and execute a non-branch word; done is also raised (and must be ignored) in ISSUE.
    task automatic do_exec(input logic [7:0] addr, input logic [15:0] word, input int exec_cycles);
        logic [7:0] nxt;
        nxt = addr + 8'd1;
        do_fetch(addr, 0, word);
        check("start_low_decode", 32'(core_start), 32'd0);
        tick();
        check("issue_start", 32'(core_start), 32'd1);
        check("issue_inst", 32'(core_inst), 32'(word));
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("exec_start_low", 32'(core_start), 32'd0);
        check("exec_inst", 32'(core_inst), 32'(word));
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_req_low", 32'(mem_req), 32'd0);
        for (int i = 1; i < exec_cycles; i++) begin
            tick();
            check("exec_hold", 32'(core_inst), 32'(word));
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("next_req", 32'(mem_req), 32'd1);
        check("next_addr", 32'(mem_addr), 32'(nxt));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        core_done  = 1'b0;
        cmp_in     = 2'd0;

        // Reset state.
        #12;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_start", 32'(core_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_wdt", 32'(wdt_err), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_inst", 32'(core_inst), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("idle_no_start", 32'(busy), 32'd0);

        // Start, immediate grant, one instruction.
        start = 1'b1;
        tick();
        start = 1'b0;
        do_exec(8'h00, 16'h0041, 1);
        #1 check("one_start", 32'(n_starts), 32'd1);

        // Branches: grant withheld 3 cycles on the first; each condition exercised.
        do_branch(8'h01, 3, 16'h0502, 2'd0, 8'h50);   // EQ taken
        do_branch(8'h50, 0, 16'h0502, 2'd1, 8'h51);   // EQ not taken
        do_branch(8'h51, 0, 16'h050A, 2'd2, 8'h50);   // LT taken
        do_branch(8'h50, 0, 16'h0502, 2'd3, 8'h51);   // reserved cmp never matches
        do_branch(8'h51, 0, 16'h0506, 2'd1, 8'h50);   // GT taken
        do_branch(8'h50, 0, 16'h0FFE, 2'd3, 8'hFF);   // always, target 0xFF
        #1 check("branch_no_start", 32'(n_starts), 32'd1);

        // pc wraps from 0xFF to 0x00 after a multi-cycle EXEC.
        do_exec(8'hFF, 16'h1234, 3);

        // Jump away, then halt.
        do_branch(8'h00, 0, 16'h0A3E, 2'd0, 8'hA3);
        do_fetch(8'hA3, 0, 16'hFFFF);
        tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_req", 32'(mem_req), 32'd0);
        check("halt_pc", 32'(pc), 32'hA3);
        tick();
        tick();
        check("halt_pc_frozen", 32'(pc), 32'hA3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_req", 32'(mem_req), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'd0);
        check("restart_halted", 32'(halted), 32'd0);

        // start ignored in EXEC, then reset asserted mid-EXEC.
        do_exec(8'h00, 16'h0041, 2);
        do_fetch(8'h01, 0, 16'h1234);
        tick();
        tick();
        check("pre_rst_inst", 32'(core_inst), 32'h1234);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ign_busy", 32'(busy), 32'd1);
        check("start_ign_req", 32'(mem_req), 32'd0);
        check("start_ign_pc", 32'(pc), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_inst", 32'(core_inst), 32'd0);
        check("async_req", 32'(mem_req), 32'd0);
        check("async_pc", 32'(pc), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        tick();
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hFFFF;
        tick();
        mem_rvalid = 1'b0;
        tick();
        check("stale_rvalid_busy", 32'(busy), 32'd0);
        check("stale_rvalid_halt", 32'(halted), 32'd0);
        check("stale_rvalid_req", 32'(mem_req), 32'd0);
        check("stale_rvalid_inst", 32'(core_inst), 32'd0);
        #1 check("start_total", 32'(n_starts), 32'd4);

`ifdef BITTY_FETCH_WDT_EN
        // Watchdog: core_done never arrives; trips on the 64th EXEC cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        do_fetch(8'h00, 0, 16'h0041);
        tick();
        tick();
        for (int i = 0; i < 63; i++) tick();
        check("wdt_not_yet", 32'(wdt_err), 32'd0);
        check("wdt_still_busy", 32'(busy), 32'd1);
        tick();
        check("wdt_err", 32'(wdt_err), 32'd1);
        check("wdt_halted", 32'(halted), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wdt_sticky", 32'(wdt_err), 32'd1);
        check("wdt_restart_req", 32'(mem_req), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
